// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter in front of a single combinational-read DataMemory port.
// Optional round-robin arbitration via DMEM_ARB_ROUND_ROBIN_EN (fixed priority to requester 0 otherwise).
module data_memory_arbiter #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         req0_valid_i,
    output logic         req0_ready_o,
    input  logic         req0_we_i,
    input  logic [N-1:0] req0_addr_i,
    input  logic [N-1:0] req0_wdata_i,
    output logic         rsp0_valid_o,
    output logic [N-1:0] rsp0_rdata_o,
    input  logic         req1_valid_i,
    output logic         req1_ready_o,
    input  logic         req1_we_i,
    input  logic [N-1:0] req1_addr_i,
    input  logic [N-1:0] req1_wdata_i,
    output logic         rsp1_valid_o,
    output logic [N-1:0] rsp1_rdata_o,
    output logic [N-1:0] mem_addr_o,
    output logic         mem_enable_data_o,
    output logic [N-1:0] mem_write_data_o,
    input  logic [N-1:0] mem_read_data_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         gnt_q, gnt_d;
    logic         last_grant_q, last_grant_d;
    logic         we_q, we_d;
    logic [N-1:0] addr_q, addr_d;
    logic [N-1:0] wdata_q, wdata_d;
    logic [N-1:0] rdata_q, rdata_d;

    logic idle;
    logic win1;
    logic handshake;

    assign idle = (state_q == IDLE);

    // win1: requester 1 takes the grant this cycle (only meaningful while it is valid)
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    assign win1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);
`else
    assign win1 = req1_valid_i & ~req0_valid_i;
`endif

    assign req0_ready_o = idle & req0_valid_i & ~win1;
    assign req1_ready_o = idle & win1;
    assign handshake    = req0_ready_o | req1_ready_o;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d      = ACCESS;
                    gnt_d        = win1;
                    last_grant_d = win1;
                    we_d         = win1 ? req1_we_i    : req0_we_i;
                    addr_d       = win1 ? req1_addr_i  : req0_addr_i;
                    wdata_d      = win1 ? req1_wdata_i : req0_wdata_i;
                end
            end
            ACCESS: begin
                // Writes return zero data; the response pulse is the write ack.
                rdata_d = we_q ? '0 : mem_read_data_i;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign mem_addr_o        = addr_q;
    assign mem_write_data_o  = wdata_q;
    assign mem_enable_data_o = (state_q == ACCESS) & we_q;

    assign rsp0_valid_o = (state_q == RESP) & ~gnt_q;
    assign rsp1_valid_o = (state_q == RESP) &  gnt_q;
    assign rsp0_rdata_o = rsp0_valid_o ? rdata_q : '0;
    assign rsp1_rdata_o = rsp1_valid_o ? rdata_q : '0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural DataMemory model.
module tb_data_memory_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_we;
    logic [N-1:0] req0_addr, req0_wdata;
    logic         rsp0_valid;
    logic [N-1:0] rsp0_rdata;
    logic         req1_valid, req1_ready, req1_we;
    logic [N-1:0] req1_addr, req1_wdata;
    logic         rsp1_valid;
    logic [N-1:0] rsp1_rdata;
    logic [N-1:0] mem_addr, mem_write_data, mem_read_data;
    logic         mem_enable_data;

    logic [N-1:0] mem [256];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_enable_data) mem[mem_addr[7:0]] <= mem_write_data;

    data_memory_arbiter #(.N(N)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_we_i(req0_we),
        .req0_addr_i(req0_addr), .req0_wdata_i(req0_wdata),
        .rsp0_valid_o(rsp0_valid), .rsp0_rdata_o(rsp0_rdata),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_we_i(req1_we),
        .req1_addr_i(req1_addr), .req1_wdata_i(req1_wdata),
        .rsp1_valid_o(rsp1_valid), .rsp1_rdata_o(rsp1_rdata),
        .mem_addr_o(mem_addr), .mem_enable_data_o(mem_enable_data),
        .mem_write_data_o(mem_write_data), .mem_read_data_i(mem_read_data)
    );

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ready0"}, {31'd0, req0_ready}, 0);
        chk({tag, " ready1"}, {31'd0, req1_ready}, 0);
        chk({tag, " rsp0_valid"}, {31'd0, rsp0_valid}, 0);
        chk({tag, " rsp1_valid"}, {31'd0, rsp1_valid}, 0);
        chk({tag, " rsp0_rdata"}, rsp0_rdata, 0);
        chk({tag, " rsp1_rdata"}, rsp1_rdata, 0);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_write_data, 0);
        chk({tag, " mem_en"}, {31'd0, mem_enable_data}, 0);
    endtask

    task automatic drive(input bit port, input logic vld, input logic we,
                         input logic [N-1:0] addr, input logic [N-1:0] wdata);
        if (port) begin
            req1_valid = vld; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = vld; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end
    endtask

    // One isolated access: handshake at T, ACCESS at T+1, response at T+2, idle at T+3.
    task automatic do_req(input string tag, input bit port, input logic we,
                          input logic [N-1:0] addr, input logic [N-1:0] wdata,
                          input logic [N-1:0] exp_rdata);
        @(negedge clk);
        drive(port, 1'b1, we, addr, wdata);
        #1;
        chk({tag, " T ready_own"}, {31'd0, port ? req1_ready : req0_ready}, 1);
        chk({tag, " T ready_other"}, {31'd0, port ? req0_ready : req1_ready}, 0);
        @(negedge clk);
        drive(port, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #1;
        chk({tag, " T+1 mem_en"}, {31'd0, mem_enable_data}, {31'd0, we});
        chk({tag, " T+1 mem_addr"}, mem_addr, addr);
        chk({tag, " T+1 rsp_valid"}, {31'd0, rsp0_valid | rsp1_valid}, 0);
        if (we) chk({tag, " T+1 mem_wdata"}, mem_write_data, wdata);
        @(negedge clk);
        #1;
        chk({tag, " T+2 rsp_own"}, {31'd0, port ? rsp1_valid : rsp0_valid}, 1);
        chk({tag, " T+2 rsp_other"}, {31'd0, port ? rsp0_valid : rsp1_valid}, 0);
        chk({tag, " T+2 rdata"}, port ? rsp1_rdata : rsp0_rdata, exp_rdata);
        chk({tag, " T+2 mem_en"}, {31'd0, mem_enable_data}, 0);
        @(negedge clk);
        #1;
        chk({tag, " T+3 rsp_own"}, {31'd0, port ? rsp1_valid : rsp0_valid}, 0);
    endtask

    initial begin : main
        int grants[4];
        int ng, last_cyc, nrsp, nreq;
        logic [N-1:0] exp_d;

        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[8'h10] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        do_req("single_read", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        do_req("write", 1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'h0);
        chk("write mem_content", mem[8'h20], 32'h1234_5678);
        do_req("read_back", 1'b1, 1'b0, 32'h20, 32'h0, 32'h1234_5678);

        // Contention: both requesters held valid for four grants.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 0);
        drive(1'b1, 1'b1, 1'b0, 32'h20, 0);
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            #1;
            if (req0_ready && req1_ready) chk("contention both_ready", 2, 1);
            if (req1_ready) begin grants[ng] = 1; ng++; end
            else if (req0_ready) begin grants[ng] = 0; ng++; end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        chk("contention grant_count", ng, 4);
        for (int k = 0; k < ng; k++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            chk($sformatf("contention grant%0d", k), grants[k], k % 2);
`else
            chk($sformatf("contention grant%0d", k), grants[k], 0);
`endif
        end
        repeat (3) @(negedge clk);

        // Stall: req1 arrives while req0 is in flight and must wait for IDLE.
        drive(1'b0, 1'b1, 1'b0, 32'h10, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 32'h30, 0);
        #1 chk("stall ready1@ACCESS", {31'd0, req1_ready}, 0);
        @(negedge clk);
        #1 chk("stall ready1@RESP", {31'd0, req1_ready}, 0);
        chk("stall rsp0 data", rsp0_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        #1 chk("stall ready1@IDLE", {31'd0, req1_ready}, 1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        #1 chk("stall mem_addr", mem_addr, 32'h30);
        @(negedge clk);
        #1 chk("stall rsp1_valid", {31'd0, rsp1_valid}, 1);
        chk("stall rsp1 data", rsp1_rdata, 32'hC0DE_0030);
        nrsp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 if (rsp1_valid) nrsp++;
        end
        chk("stall single_accept", nrsp, 0);

        // Reset during ACCESS abandons the read.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h44, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        #1 chk("rst_mid in_access", mem_addr, 32'h44);
        rst_n = 1'b0;
        @(negedge clk);
        #1 chk_all_zero("rst_mid after");
        rst_n = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 if (rsp0_valid) nrsp++;
        end
        chk("rst_mid no_rsp", nrsp, 0);
        do_req("post_reset", 1'b0, 1'b0, 32'h48, 32'h0, 32'hC0DE_0048);

        // Throughput: ten back-to-back reads, one response every 3 cycles.
        nreq = 0; nrsp = 0; last_cyc = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            drive(1'b0, nreq < 10, 1'b0, 32'h40 + 4 * nreq, 0);
            #1;
            if (rsp0_valid) begin
                exp_d = 32'hC0DE_0040 + 4 * nrsp;
                chk($sformatf("tput data%0d", nrsp), rsp0_rdata, exp_d);
                if (nrsp > 0) chk($sformatf("tput spacing%0d", nrsp), c - last_cyc, 3);
                last_cyc = c;
                nrsp++;
            end
            if (req0_ready) nreq++;
        end
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        chk("tput rsp_count", nrsp, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
